// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the I/D main-memory port arbiter.
// Holds the FSM state encoding, the owner encoding and the default line geometry.
package mem_port_arbiter_pkg;

    localparam int LINE_ADDR_LEN_DEF = 3;
    localparam int LINE_WORDS        = 1 << LINE_ADDR_LEN_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-input round-robin grant. A tie goes to the side that did not own the port
// last; last_owner is updated when a burst completes.
module rr_arbiter2
    import mem_port_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic d_req,
    input  logic update,
    input  logic upd_owner,
    output logic gnt,
    output logic gnt_owner
);

    owner_t last_owner_r;

    // Remember who finished last; starting as I lets D win the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner_r <= OWN_I;
        end else if (update) begin
            last_owner_r <= owner_t'(upd_owner);
        end else begin
            last_owner_r <= last_owner_r;
        end
    end

    // Grant selection: a lone requester wins outright, a tie alternates
    always_comb begin
        gnt       = i_req | d_req;
        gnt_owner = OWN_I;
        if (i_req && d_req) begin
            gnt_owner = (last_owner_r == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            gnt_owner = OWN_D;
        end else begin
            gnt_owner = OWN_I;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported main memory between the I-cache and D-cache line
// engines: round-robin grant, word-address sequencing, handshake forwarding.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
    parameter int ADDR_W        = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_req,
    input  logic                     i_wr,
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic [31:0]              i_wdata,
    output logic [LINE_ADDR_LEN-1:0] i_widx,
    output logic [31:0]              i_rdata,
    output logic                     i_rvalid,
    output logic                     i_done,
    input  logic                     d_req,
    input  logic                     d_wr,
    input  logic [ADDR_W-1:0]        d_addr,
    input  logic [31:0]              d_wdata,
    output logic [LINE_ADDR_LEN-1:0] d_widx,
    output logic [31:0]              d_rdata,
    output logic                     d_rvalid,
    output logic                     d_done,
    output logic                     mem_req,
    output logic                     mem_wr,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata,
    input  logic                     mem_ack,
    output logic [31:0]              i_grant_cnt,
    output logic [31:0]              d_grant_cnt
);

    localparam logic [ADDR_W-1:0] OFF_MASK =
        ADDR_W'((64'd1 << (LINE_ADDR_LEN + 2)) - 64'd1);
    localparam logic [LINE_ADDR_LEN-1:0] LAST_IDX = {LINE_ADDR_LEN{1'b1}};

    state_t                     state_r;
    state_t                     state_nx_s;
    logic                       owner_r;
    logic                       wr_r;
    logic [ADDR_W-1:0]          base_r;
    logic [LINE_ADDR_LEN-1:0]   cnt_r;
    logic [31:0]                i_cnt_r;
    logic [31:0]                d_cnt_r;
    logic                       gnt_s;
    logic                       gnt_owner_s;
    logic                       burst_s;
    logic                       rd_ack_s;

    rr_arbiter2 u_rr (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .d_req     (d_req),
        .update    (state_r == ST_DONE),
        .upd_owner (owner_r),
        .gnt       (gnt_s),
        .gnt_owner (gnt_owner_s)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; the burst ends on the ack of the last word of the line
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (gnt_s) state_nx_s = ST_BURST;
                else       state_nx_s = ST_IDLE;
            end
            ST_BURST: begin
                if (mem_ack && (cnt_r == LAST_IDX)) state_nx_s = ST_DONE;
                else                                state_nx_s = ST_BURST;
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Burst context: owner, direction and line base are frozen at grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_r <= OWN_I;
            wr_r    <= 1'b0;
            base_r  <= {ADDR_W{1'b0}};
            cnt_r   <= {LINE_ADDR_LEN{1'b0}};
            i_cnt_r <= 32'd0;
            d_cnt_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (gnt_s) begin
                        owner_r <= gnt_owner_s;
                        wr_r    <= (gnt_owner_s == OWN_D) ? d_wr : i_wr;
                        base_r  <= ((gnt_owner_s == OWN_D) ? d_addr : i_addr) & ~OFF_MASK;
                        cnt_r   <= {LINE_ADDR_LEN{1'b0}};
                    end
                end
                ST_BURST: begin
                    if (mem_ack) cnt_r <= cnt_r + LINE_ADDR_LEN'(1);
                end
                ST_DONE: begin
                    if (owner_r == OWN_D) d_cnt_r <= d_cnt_r + 32'd1;
                    else                  i_cnt_r <= i_cnt_r + 32'd1;
                end
                default: begin
                    cnt_r <= {LINE_ADDR_LEN{1'b0}};
                end
            endcase
        end
    end

    // Output decode; read data passes straight through on the acking cycle
    always_comb begin
        burst_s   = (state_r == ST_BURST);
        rd_ack_s  = burst_s && mem_ack && !wr_r;
        mem_req   = burst_s;
        mem_wr    = burst_s && wr_r;
        mem_addr  = burst_s ? (base_r | ADDR_W'({cnt_r, 2'b00})) : {ADDR_W{1'b0}};
        mem_wdata = 32'd0;
        if (burst_s) begin
            mem_wdata = (owner_r == OWN_D) ? d_wdata : i_wdata;
        end else begin
            mem_wdata = 32'd0;
        end
        i_widx      = (burst_s && owner_r == OWN_I) ? cnt_r : {LINE_ADDR_LEN{1'b0}};
        d_widx      = (burst_s && owner_r == OWN_D) ? cnt_r : {LINE_ADDR_LEN{1'b0}};
        i_rvalid    = rd_ack_s && (owner_r == OWN_I);
        d_rvalid    = rd_ack_s && (owner_r == OWN_D);
        i_rdata     = i_rvalid ? mem_rdata : 32'd0;
        d_rdata     = d_rvalid ? mem_rdata : 32'd0;
        i_done      = (state_r == ST_DONE) && (owner_r == OWN_I);
        d_done      = (state_r == ST_DONE) && (owner_r == OWN_D);
        i_grant_cnt = i_cnt_r;
        d_grant_cnt = d_cnt_r;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a burst-level model predicts every output
// each cycle, and directed scenarios pin addresses, ordering and counters.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_wr, d_req, d_wr;
    logic [31:0] i_addr, d_addr, i_wdata, d_wdata, i_rdata, d_rdata;
    logic [2:0]  i_widx, d_widx;
    logic        i_rvalid, d_rvalid, i_done, d_done;
    logic        mem_req, mem_wr, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] i_grant_cnt, d_grant_cnt;

    logic [31:0] i_line [8];
    logic [31:0] d_line [8];

    int pass_cnt = 0;
    int total_cnt = 0;

    // requester bookkeeping: targets written by main, done counts by the monitor
    int i_target = 0, d_target = 0, i_done_cnt = 0, d_done_cnt = 0;
    int ack_mode = 0, cyc = 0;
    int i_rv_cnt = 0, d_rv_cnt = 0, ack_burst = 0, wmatch_cnt = 0;
    logic [31:0] first_addr = 32'h0, last_addr = 32'h0;
    logic        prev_req = 1'b0;
    int          done_order [$];

    // model state: a burst is "busy" for words 0..7, then one "done" cycle
    bit          m_busy = 1'b0, m_done = 1'b0, m_own = 1'b0, m_wr = 1'b0, m_last = 1'b0;
    logic [31:0] m_base = 32'h0, m_icnt = 32'h0, m_dcnt = 32'h0;
    int          m_word = 0;
    logic [31:0] e_addr, e_wdata;
    bit          e_irv, e_drv;

    always #5 clk = ~clk;

    assign i_wdata = i_line[i_widx];
    assign d_wdata = d_line[d_widx];

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_widx(i_widx), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_widx(d_widx), .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Requesters and memory: req held until enough dones seen; ack pattern per mode
    always @(posedge clk) begin
        #1;
        cyc++;
        i_req = !rst && (i_target > i_done_cnt);
        d_req = !rst && (d_target > d_done_cnt);
        case (ack_mode)
            0:       mem_ack = 1'b1;
            1:       mem_ack = (cyc % 3 == 0);
            2:       mem_ack = 1'($urandom_range(0, 1));
            default: mem_ack = 1'b1;
        endcase
        mem_rdata = $urandom;
    end

    // Compare DUT against the model, update monitors, then advance the model
    always @(negedge clk) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_own = 0; m_wr = 0; m_last = 0;
            m_base = 32'h0; m_word = 0; m_icnt = 32'h0; m_dcnt = 32'h0;
        end
        e_addr  = m_busy ? m_base + 32'(m_word * 4) : 32'h0;
        e_wdata = m_busy ? (m_own ? d_line[m_word % 8] : i_line[m_word % 8]) : 32'h0;
        e_irv   = m_busy && !m_own && !m_wr && mem_ack;
        e_drv   = m_busy &&  m_own && !m_wr && mem_ack;
        chk("mem_req",     64'(mem_req),     64'(m_busy));
        chk("mem_wr",      64'(mem_wr),      64'(m_busy && m_wr));
        chk("mem_addr",    64'(mem_addr),    64'(e_addr));
        chk("mem_wdata",   64'(mem_wdata),   64'(e_wdata));
        chk("i_widx",      64'(i_widx),      (m_busy && !m_own) ? 64'(m_word) : 64'd0);
        chk("d_widx",      64'(d_widx),      (m_busy &&  m_own) ? 64'(m_word) : 64'd0);
        chk("i_rvalid",    64'(i_rvalid),    64'(e_irv));
        chk("d_rvalid",    64'(d_rvalid),    64'(e_drv));
        chk("i_rdata",     64'(i_rdata),     e_irv ? 64'(mem_rdata) : 64'd0);
        chk("d_rdata",     64'(d_rdata),     e_drv ? 64'(mem_rdata) : 64'd0);
        chk("i_done",      64'(i_done),      64'(m_done && !m_own));
        chk("d_done",      64'(d_done),      64'(m_done &&  m_own));
        chk("i_grant_cnt", 64'(i_grant_cnt), 64'(m_icnt));
        chk("d_grant_cnt", 64'(d_grant_cnt), 64'(m_dcnt));

        if (i_done) begin i_done_cnt++; done_order.push_back(0); end
        if (d_done) begin d_done_cnt++; done_order.push_back(1); end
        if (i_rvalid) i_rv_cnt++;
        if (d_rvalid) d_rv_cnt++;
        if (mem_req && !prev_req) first_addr = mem_addr;
        if (mem_req && mem_ack) last_addr = mem_addr;
        if (mem_req && mem_ack && mem_wr && mem_wdata === d_line[d_widx]) wmatch_cnt++;
        if (!mem_req) ack_burst = 0;
        else if (mem_ack) ack_burst++;
        prev_req = mem_req;

        if (!rst) begin
            if (m_done) begin
                if (m_own) m_dcnt = m_dcnt + 32'd1;
                else       m_icnt = m_icnt + 32'd1;
                m_last = m_own;
                m_done = 0;
            end else if (m_busy) begin
                if (mem_ack) begin
                    m_word++;
                    if (m_word == 8) begin m_busy = 0; m_done = 1; end
                end
            end else if (i_req || d_req) begin
                m_own  = (i_req && d_req) ? !m_last : d_req;
                m_wr   = m_own ? d_wr : i_wr;
                m_base = (m_own ? d_addr : i_addr) & 32'hFFFF_FFE0;
                m_word = 0;
                m_busy = 1;
            end
        end
    end

    task automatic wait_quiet(input string name);
        int n = 0;
        while ((i_done_cnt < i_target || d_done_cnt < d_target) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk({name, " completion within budget"}, 64'(n < 3000), 64'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_acks(input int k);
        int n = 0;
        while (ack_burst < k && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ack wait within budget", 64'(n < 500), 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        i_target = i_done_cnt;
        d_target = d_done_cnt;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic fill_lines();
        for (int k = 0; k < 8; k++) begin
            i_line[k] = $urandom;
            d_line[k] = $urandom;
        end
    endtask

    initial begin
        int rv0, ic0, k0;
        rst = 1'b1;
        i_req = 1'b0; d_req = 1'b0; i_wr = 1'b0; d_wr = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        fill_lines();
        repeat (3) @(posedge clk);
        #2;
        chk("reset mem_req", 64'(mem_req), 64'd0);
        chk("reset i_grant_cnt", 64'(i_grant_cnt), 64'd0);
        rst = 1'b0;

        // I read of a line at 0x1040, ack every cycle
        ack_mode = 0;
        i_addr = 32'h0000_1040; i_wr = 1'b0;
        @(negedge clk);
        rv0 = i_rv_cnt;
        i_target++;
        wait_quiet("t1");
        chk("t1 first addr", 64'(first_addr), 64'h1040);
        chk("t1 last addr", 64'(last_addr), 64'h105C);
        chk("t1 rvalid pulses", 64'(i_rv_cnt - rv0), 64'd8);
        chk("t1 i_grant_cnt", 64'(i_grant_cnt), 64'd1);

        // both request from reset: D first, then I; then alternate with both held
        do_reset();
        ack_mode = 2;
        d_addr = 32'h0000_0800; d_wr = 1'b0;
        @(negedge clk);
        k0 = done_order.size();
        i_target++; d_target++;
        wait_quiet("t2a");
        chk("t2a first served", 64'(done_order[k0]), 64'd1);
        chk("t2a second served", 64'(done_order[k0 + 1]), 64'd0);
        do_reset();
        @(negedge clk);
        k0 = done_order.size();
        i_target += 2; d_target += 2;
        wait_quiet("t2b");
        for (int k = 0; k < 4; k++) chk("t2b alternation", 64'(done_order[k0 + k]), 64'(k % 2 == 0));
        chk("t2b i count", 64'(i_grant_cnt), 64'd2);
        chk("t2b d count", 64'(d_grant_cnt), 64'd2);

        // D write at 0x2000, ack every third cycle
        ack_mode = 1;
        fill_lines();
        d_addr = 32'h0000_2000; d_wr = 1'b1;
        @(negedge clk);
        rv0 = d_rv_cnt; ic0 = wmatch_cnt; k0 = d_done_cnt;
        d_target++;
        wait_quiet("t3");
        chk("t3 d_rvalid never", 64'(d_rv_cnt - rv0), 64'd0);
        chk("t3 write words", 64'(wmatch_cnt - ic0), 64'd8);
        chk("t3 last addr", 64'(last_addr), 64'h201C);
        chk("t3 d_done", 64'(d_done_cnt - k0), 64'd1);

        // unaligned D read address is trimmed to the line base
        ack_mode = 2;
        d_addr = 32'h0000_301C; d_wr = 1'b0;
        @(negedge clk);
        d_target++;
        wait_quiet("t4");
        chk("t4 first addr", 64'(first_addr), 64'h3000);
        chk("t4 last addr", 64'(last_addr), 64'h301C);

        // reset after the third ack aborts the burst silently
        ack_mode = 0;
        i_addr = 32'h0000_4008; i_wr = 1'b0;
        @(negedge clk);
        ic0 = i_done_cnt;
        i_target++;
        wait_acks(3);
        #1;
        rst = 1'b1;
        i_target = i_done_cnt;
        #1;
        chk("t5 mem_req on reset", 64'(mem_req), 64'd0);
        chk("t5 i count cleared", 64'(i_grant_cnt), 64'd0);
        chk("t5 d count cleared", 64'(d_grant_cnt), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        chk("t5 no i_done", 64'(i_done_cnt - ic0), 64'd0);
        @(negedge clk);
        i_target++;
        wait_quiet("t5 restart");
        chk("t5 restart first addr", 64'(first_addr), 64'h4000);

        // ack while idle is ignored; address/direction change mid-burst is ignored
        ack_mode = 3;
        repeat (5) @(posedge clk);
        ack_mode = 2;
        i_addr = 32'h0000_5000; i_wr = 1'b0;
        @(negedge clk);
        rv0 = i_rv_cnt;
        i_target++;
        wait_acks(3);
        i_addr = 32'hABCD_EF00; i_wr = 1'b1;
        wait_quiet("t6");
        chk("t6 last addr", 64'(last_addr), 64'h501C);
        chk("t6 rvalid pulses", 64'(i_rv_cnt - rv0), 64'd8);

        // randomized traffic
        for (int r = 0; r < 20; r++) begin
            @(negedge clk);
            fill_lines();
            i_addr = $urandom; d_addr = $urandom;
            i_wr = 1'($urandom_range(0, 1)); d_wr = 1'($urandom_range(0, 1));
            ack_mode = (r % 4 == 0) ? 0 : 2;
            i_target += $urandom_range(0, 2);
            d_target += $urandom_range(1, 2);
            wait_quiet("random");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported main-memory interface between the instruction-cache and data-cache line-transfer engines.
- Each requester asks for a whole-line burst (refill read or writeback write). The arbiter grants round-robin, sequences the word addresses, forwards the handshake, and signals completion.
- Sits between both cache instances and main memory; free-running grant counters feed performance statistics.

Parameters:
- LINE_ADDR_LEN, 3, log2 of words per line (LINE_WORDS = 2^LINE_ADDR_LEN = 8).
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- i_req  in  1  I-side burst request, level, held until i_done
- i_wr  in  1  I-side direction, 1 = write; sampled at grant
- i_addr  in  ADDR_W  I-side line byte address; sampled at grant
- i_wdata  in  32  I-side write word selected by i_widx
- i_widx  out  LINE_ADDR_LEN  current word index of the I-side burst
- i_rdata  out  32  read word returned to the I side
- i_rvalid  out  1  i_rdata valid, one pulse per word
- i_done  out  1  one-cycle burst-complete pulse
- d_req, d_wr, d_addr, d_wdata, d_widx, d_rdata, d_rvalid, d_done: same as the i_* ports, for the D side
- mem_req  out  1  memory access request
- mem_wr  out  1  memory write enable
- mem_addr  out  ADDR_W  memory word byte address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid with mem_ack
- mem_ack  in  1  memory completes the current word
- i_grant_cnt  out  32  completed I-side bursts
- d_grant_cnt  out  32  completed D-side bursts

Behaviour:
- FSM states: IDLE, BURST, DONE.
- Reset (async): state IDLE, all outputs 0, word counter 0, owner 0, last_owner = I (so D wins the first tie), counters 0. Reset during a burst aborts it with no done pulse.
- IDLE arbitration:
  - Only one requester active: grant it.
  - Both active: grant the side that is not last_owner.
  - On grant, latch owner, wr and base = addr with bits [LINE_ADDR_LEN+1:0] forced to 0; counter = 0; go to BURST.
- BURST:
  - mem_req = 1, mem_wr = latched wr, mem_addr = base + (counter << 2).
  - mem_wdata = owner's *_wdata; owner's *_widx = counter. The requester drives *_wdata combinationally from *_widx.
  - mem_ack low: hold all outputs (unbounded stall allowed).
  - mem_ack high on a read: owner's *_rdata = mem_rdata and *_rvalid = 1 in the same cycle (combinational pass-through).
  - mem_ack high: counter increments. On the ack with counter == LINE_WORDS-1, go to DONE. The counter wraps to 0 and never exceeds the line.
- DONE (exactly one cycle):
  - mem_req = 0; owner's *_done = 1; owner's grant counter += 1 (wraps at 2^32); last_owner = owner.
  - Both req inputs are ignored in this cycle. The requester deasserts req on the edge that samples done, so it is low in the next IDLE.
  - Next state IDLE. A new grant is therefore never earlier than 2 cycles after the final ack.
- Latency: mem_req rises on the cycle after grant. Minimum burst = LINE_WORDS + 2 cycles (grant edge, 8 acks, DONE).
- mem_ack outside BURST is ignored.
- Non-owner *_rvalid, *_done and *_widx stay 0.
- Changes to req, addr or wr during a burst are ignored until the next IDLE.
- A write burst's *_rvalid never asserts.

Decomposition:
- Shared package: state encoding (IDLE/BURST/DONE), owner encoding (OWN_I = 0, OWN_D = 1), LINE_WORDS constant.
- One natural sub-module: rr_arbiter2, a 2-input round-robin grant with last_owner register.
- Datapath muxing and the FSM stay in the top module.

Test Plan:
- I read, base 0x0000_1040, mem_ack every cycle -> mem_addr steps 0x1040, 0x1044 … 0x105C; 8 i_rvalid pulses carrying mem_rdata; i_done one cycle after the 8th ack; i_grant_cnt = 1.
- i_req and d_req both raised from reset -> D is served first, then I. Repeat with both held -> grants alternate D, I, D, I; counters 2/2 after 4 bursts.
- D write, base 0x2000; mem_ack asserted every third cycle -> mem_wdata = d_wdata[d_widx] for widx 0..7; mem_wr = 1 throughout; d_rvalid never 1; d_done after the 8th ack.
- Unaligned d_addr 0x0000_301C -> base latched as 0x3000; first mem_addr = 0x3000, last = 0x301C.
- rst pulsed after the 3rd ack of an I burst -> mem_req = 0 immediately, no i_done, counters 0; a fresh request then starts at word 0.
- mem_ack pulsed while IDLE, and i_addr changed mid-burst -> no counter advance, no rvalid, mem_addr continues from the latched base.
